// File: rtl/gpio_in_port_if.sv
// picoRV32 native memory bus bundle between the CPU (master) and a peripheral (slave).
// Combinational wires only; the peripheral answers with one mem_ready pulse per request, no backpressure.
interface gpio_in_port_if;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wstrb,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wstrb,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/gpio_in_port.sv
// Debounced memory-mapped input port with edge interrupts; pin-to-STABLE 2+DEBOUNCE_CYCLES clk, bus ack 1 clk.
// The CPU holds mem_valid until mem_ready; every selected request gets exactly one ready pulse, never back-to-back.
module gpio_in_port #(
    parameter int          WIDTH           = 8,
    parameter int          DEBOUNCE_CYCLES = 16000,
    parameter logic [31:0] BASE_ADDR       = 32'h0300_0100
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] pins,
    gpio_in_port_if.slave    bus,
    output logic             irq
);

    localparam int            CW       = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [2:0] REG_STABLE  = 3'd0;
    localparam logic [2:0] REG_RAW     = 3'd1;
    localparam logic [2:0] REG_PEND    = 3'd2;
    localparam logic [2:0] REG_RISE_EN = 3'd3;
    localparam logic [2:0] REG_FALL_EN = 3'd4;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             irq_q, irq_d;

    logic             sel;
    logic             accept;
    logic             wr;
    logic             rd;
    logic [2:0]       reg_idx;
    logic [31:0]      byte_mask;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wdata_w;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pend_clr;
    logic [31:0]      rd_word;
    logic             unused_bits;

    // Synchroniser and per-bit debounce counters.
    always_comb begin
        sync1_d  = pins;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]    = '0;
                stable_d[i] = sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
    end

    // Bus decode: a request is accepted once, in the cycle before the ready pulse.
    always_comb begin
        sel       = bus.mem_valid && (bus.mem_addr[31:5] == BASE_ADDR[31:5]);
        accept    = sel && !ready_q;
        wr        = accept && (bus.mem_wstrb != 4'b0000);
        rd        = accept && (bus.mem_wstrb == 4'b0000);
        reg_idx   = bus.mem_addr[4:2];
        byte_mask = {{8{bus.mem_wstrb[3]}}, {8{bus.mem_wstrb[2]}},
                     {8{bus.mem_wstrb[1]}}, {8{bus.mem_wstrb[0]}}};
        wmask     = byte_mask[WIDTH-1:0];
        wdata_w   = bus.mem_wdata[WIDTH-1:0];
    end

    assign unused_bits = ^{bus.mem_addr[1:0], bus.mem_wdata, byte_mask};

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        pend_clr  = '0;
        if (wr) begin
            case (reg_idx)
                REG_PEND:    pend_clr  = wdata_w & wmask;
                REG_RISE_EN: rise_en_d = (rise_en_q & ~wmask) | (wdata_w & wmask);
                REG_FALL_EN: fall_en_d = (fall_en_q & ~wmask) | (wdata_w & wmask);
                default:     ;
            endcase
        end
        // Edge qualification uses the enables as they were before any same-cycle write; a set beats a clear.
        pend_d = (pend_q & ~pend_clr) | (rise & rise_en_q) | (fall & fall_en_q);
        irq_d  = |pend_q;
    end

    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_STABLE:  rd_word[WIDTH-1:0] = stable_q;
            REG_RAW:     rd_word[WIDTH-1:0] = sync2_q;
            REG_PEND:    rd_word[WIDTH-1:0] = pend_q;
            REG_RISE_EN: rd_word[WIDTH-1:0] = rise_en_q;
            REG_FALL_EN: rd_word[WIDTH-1:0] = fall_en_q;
            default:     rd_word = '0;
        endcase
        ready_d = accept;
        rdata_d = rd ? rd_word : 32'h0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            pend_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= 32'h0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_q    <= pend_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_in_port.sv
// Bench for gpio_in_port with a short debounce window: vector table plus hand-written edge/reset sequences.
// Read data is checked by a scoreboard fed when each access is driven and drained on mem_ready.
module tb_gpio_in_port;

    localparam int          W    = 8;
    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'h0300_0100;

    logic         clk = 1'b0;
    logic         resetn;
    logic [W-1:0] pins;
    logic         irq;

    gpio_in_port_if bus ();

    gpio_in_port #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D),
        .BASE_ADDR       (BASE)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .pins   (pins),
        .bus    (bus),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [7:0]  pins;
        int          hold;
        logic [4:0]  off;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Caller is positioned 1 time unit after a rising edge.
    task automatic bus_xfer(input logic [4:0] off, input logic [3:0] strb,
                            input logic [31:0] wd, input logic [31:0] exp);
        int cyc;
        bit got;
        if (bus.mem_ready) begin
            @(posedge clk);
            #1;
        end
        sb_q.push_back(exp);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = {BASE[31:5], off};
        bus.mem_wstrb = strb;
        bus.mem_wdata = wd;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 4) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_ready === 1'b1) got = 1'b1;
        end
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = 32'h0;
        if (!got) void'(sb_q.pop_back());
        check($sformatf("ready_latency@%h", off), 32'(cyc), 32'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.mem_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_ready: got mem_ready=1 rdata=%h, expected no ready", bus.mem_rdata);
            end else begin
                check("rdata", bus.mem_rdata, sb_q.pop_front());
            end
        end else if (bus.mem_rdata !== 32'h0) begin
            check("rdata_idle", bus.mem_rdata, 32'h0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{8'hFF,  0, 5'h00, 4'h0, 32'h0000_0000, 32'h0000_00FF};
        tbl[1]  = '{8'hA5, 10, 5'h04, 4'h0, 32'h0000_0000, 32'h0000_00A5};
        tbl[2]  = '{8'hA5,  0, 5'h00, 4'h0, 32'h0000_0000, 32'h0000_00A5};
        tbl[3]  = '{8'hA5,  0, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[4]  = '{8'hA5,  0, 5'h0C, 4'h1, 32'hFFFF_FF00, 32'h0000_0000};
        tbl[5]  = '{8'hA5,  0, 5'h0C, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[6]  = '{8'hA5,  0, 5'h10, 4'h2, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7]  = '{8'hA5,  0, 5'h10, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[8]  = '{8'hA5,  0, 5'h14, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[9]  = '{8'hA5,  0, 5'h14, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[10] = '{8'hA5,  0, 5'h1C, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[11] = '{8'hA5,  0, 5'h10, 4'hF, 32'h0000_0081, 32'h0000_0000};
        tbl[12] = '{8'hA5,  0, 5'h10, 4'h0, 32'h0000_0000, 32'h0000_0081};
        tbl[13] = '{8'h3C, 10, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0081};
        tbl[14] = '{8'h3C,  0, 5'h08, 4'h1, 32'h0000_0001, 32'h0000_0000};
        tbl[15] = '{8'h3C,  0, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0080};
        tbl[16] = '{8'h3C,  0, 5'h08, 4'h2, 32'h0000_8080, 32'h0000_0000};
        tbl[17] = '{8'h3C,  0, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0080};
        tbl[18] = '{8'h3C,  0, 5'h0C, 4'h1, 32'hFFFF_FF5A, 32'h0000_0000};
        tbl[19] = '{8'h3C,  0, 5'h0C, 4'h0, 32'h0000_0000, 32'h0000_005A};
        tbl[20] = '{8'h3C,  0, 5'h0C, 4'hF, 32'h0000_0000, 32'h0000_0000};
        tbl[21] = '{8'h3C,  0, 5'h08, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[22] = '{8'h3C,  0, 5'h08, 4'h0, 32'h0000_0000, 32'h0000_0000};
        tbl[23] = '{8'h3C,  0, 5'h10, 4'hF, 32'h0000_0000, 32'h0000_0000};

        resetn        = 1'b0;
        pins          = 8'hFF;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wstrb = 4'h0;
        bus.mem_wdata = 32'h0;

        // Reset state, then STABLE must take exactly 2+D clocks to follow pins held high.
        #12;
        check("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
        check("rst_rdata", bus.mem_rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_stable", {24'b0, dut.stable_q}, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick(5);
        check("stable_before_6clk", {24'b0, dut.stable_q}, 32'h0);
        tick(1);
        check("stable_at_6clk", {24'b0, dut.stable_q}, 32'hFF);
        bus_xfer(5'h08, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            pins = tbl[i].pins;
            if (tbl[i].hold > 0) tick(tbl[i].hold);
            bus_xfer(tbl[i].off, tbl[i].strb, tbl[i].wdata, tbl[i].exp);
        end

        // Debounce: a held rise lands after 6 clocks, a 3-clock pulse is rejected.
        pins = 8'h3D;
        tick(5);
        check("deb_bit0_5clk", {31'b0, dut.stable_q[0]}, 32'h0);
        tick(1);
        check("deb_bit0_6clk", {31'b0, dut.stable_q[0]}, 32'h1);
        pins = 8'h3F;
        tick(3);
        pins = 8'h3D;
        tick(10);
        check("deb_glitch", {24'b0, dut.stable_q}, 32'h3D);
        bus_xfer(5'h00, 4'h0, 32'h0, 32'h3D);

        // Rising edge on bit 3 raises PEND, irq one clock later; W1C drops irq the clock after.
        bus_xfer(5'h0C, 4'hF, 32'h08, 32'h0);
        pins = 8'h35;
        tick(10);
        bus_xfer(5'h08, 4'h0, 32'h0, 32'h0);
        pins = 8'h3D;
        tick(6);
        check("irq_pend_set", {24'b0, dut.pend_q}, 32'h08);
        check("irq_lag", {31'b0, irq}, 32'h0);
        tick(1);
        check("irq_asserted", {31'b0, irq}, 32'h1);
        bus_xfer(5'h08, 4'h0, 32'h0, 32'h08);
        bus_xfer(5'h08, 4'h1, 32'h08, 32'h0);
        check("w1c_pend", {24'b0, dut.pend_q}, 32'h0);
        check("w1c_irq_still", {31'b0, irq}, 32'h1);
        tick(1);
        check("w1c_irq_drop", {31'b0, irq}, 32'h0);

        // Rise on bit 2 in the same clock as its W1C: the set must win.
        bus_xfer(5'h0C, 4'hF, 32'h04, 32'h0);
        pins = 8'h39;
        tick(10);
        pins = 8'h3D;
        tick(5);
        bus_xfer(5'h08, 4'hF, 32'h04, 32'h0);
        check("collide_pend", {24'b0, dut.pend_q}, 32'h04);
        tick(1);
        check("collide_irq", {31'b0, irq}, 32'h1);
        bus_xfer(5'h08, 4'h0, 32'h0, 32'h04);
        bus_xfer(5'h08, 4'hF, 32'hFF, 32'h0);

        // Outside the window: no acknowledge at all.
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0300_0200;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("nosel_ready", {31'b0, bus.mem_ready}, 32'h0);
        end
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;

        // Reset while a request is outstanding: it is dropped, registers come back cleared.
        pins = 8'h00;
        tick(10);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE;
        #3;
        resetn        = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_addr  = 32'h0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check("rst_mid_ready", {31'b0, bus.mem_ready}, 32'h0);
        end
        resetn = 1'b1;
        tick(1);
        for (int r = 0; r < 5; r++) begin
            bus_xfer(5'(r * 4), 4'h0, 32'h0, 32'h0);
        end

        tick(2);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
